// File: rtl/call_stack_ctrl_if.sv
// Handshake/bus bundle for call_stack_ctrl.
// master: request side (enable, call/ret/irq requests, clr_fault, offset);
//         observes pc, level, top, busy, irq_ack, fault, fault_code.
// slave:  the controller itself, the mirror image of master.
interface call_stack_ctrl_if #(
  parameter int unsigned PC_W  = 11,
  parameter int unsigned OFS_W = 10
);
  logic             enable;
  logic             call_req;
  logic             ret_req;
  logic             irq_req;
  logic             clr_fault;
  logic [OFS_W-1:0] offset;
  logic [PC_W-1:0]  pc;
  logic [2:0]       level;
  logic [PC_W-1:0]  top;
  logic             busy;
  logic             irq_ack;
  logic             fault;
  logic [1:0]       fault_code;

  modport master (
    output enable, call_req, ret_req, irq_req, clr_fault, offset,
    input  pc, level, top, busy, irq_ack, fault, fault_code
  );

  modport slave (
    input  enable, call_req, ret_req, irq_req, clr_fault, offset,
    output pc, level, top, busy, irq_ack, fault, fault_code
  );
endinterface

// File: rtl/call_stack_ctrl.sv
// Program-counter sequencer with a small hardware return stack.
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - synchronous active-low reset, overrides everything
//   bus   - call_stack_ctrl_if.slave: enable, call/ret/irq requests, clr_fault,
//           signed offset in; pc, level, top, busy, irq_ack, fault, fault_code out
// One request per RUN cycle (irq > ret > call); each accepted request is followed
// by a single BUBBLE cycle. Overflow/underflow parks the block in FAULT until
// clr_fault or reset.
module call_stack_ctrl #(
  parameter int unsigned     PC_W    = 11,
  parameter int unsigned     OFS_W   = 10,
  parameter int unsigned     DEPTH   = 4,
  parameter logic [PC_W-1:0] IRQ_VEC = 11'h7F0
) (
  input logic              clk,
  input logic              rst_n,
  call_stack_ctrl_if.slave bus
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  DEPTH_L = 3'(DEPTH);

  typedef enum logic [1:0] {StRun, StBubble, StFault} state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [2:0]      level_q;
  logic [PC_W-1:0] stack_q [DEPTH];
  logic            irq_ack_q;
  logic [1:0]      fault_code_q;

  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;
  logic [PC_W-1:0]  ofs_ext;
  logic             full;
  logic             empty;

  // Entries live at [0 .. level-1]; the next push lands at index level.
  assign push_idx = IDX_W'(level_q);
  assign top_idx  = IDX_W'(level_q - 3'd1);
  assign full     = (level_q == DEPTH_L);
  assign empty    = (level_q == 3'd0);
  // Casting the signed offset to the wider pc width sign-extends it.
  assign ofs_ext  = PC_W'($signed(bus.offset));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StRun;
      pc_q         <= '0;
      level_q      <= '0;
      irq_ack_q    <= 1'b0;
      fault_code_q <= 2'b00;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else if (!bus.enable) begin
      // Frozen, but the acknowledge pulse must not linger across a stall.
      irq_ack_q <= 1'b0;
    end else begin
      irq_ack_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (bus.irq_req) begin
            if (full) begin
              fault_code_q <= 2'b11;
              state_q      <= StFault;
            end else begin
              stack_q[push_idx] <= pc_q;
              pc_q              <= IRQ_VEC;
              level_q           <= level_q + 3'd1;
              irq_ack_q         <= 1'b1;
              state_q           <= StBubble;
            end
          end else if (bus.ret_req) begin
            if (empty) begin
              fault_code_q <= 2'b10;
              state_q      <= StFault;
            end else begin
              pc_q             <= stack_q[top_idx] + PC_W'(1);
              stack_q[top_idx] <= '0;
              level_q          <= level_q - 3'd1;
              state_q          <= StBubble;
            end
          end else if (bus.call_req) begin
            if (full) begin
              fault_code_q <= 2'b01;
              state_q      <= StFault;
            end else begin
              stack_q[push_idx] <= pc_q;
              pc_q              <= pc_q + ofs_ext;
              level_q           <= level_q + 3'd1;
              state_q           <= StBubble;
            end
          end else begin
            pc_q <= pc_q + PC_W'(1);
          end
        end
        StBubble: state_q <= StRun;
        StFault: begin
          if (bus.clr_fault) begin
            pc_q         <= '0;
            level_q      <= '0;
            fault_code_q <= 2'b00;
            state_q      <= StRun;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign bus.pc         = pc_q;
  assign bus.level      = level_q;
  assign bus.top        = empty ? '0 : stack_q[top_idx];
  assign bus.busy       = (state_q != StRun);
  assign bus.fault      = (state_q == StFault);
  assign bus.irq_ack    = irq_ack_q;
  assign bus.fault_code = fault_code_q;

endmodule

// File: tb/tb_call_stack_ctrl.sv
module tb_call_stack_ctrl;
  localparam int unsigned PC_W  = 11;
  localparam int unsigned OFS_W = 10;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IRQ_V = 'h7F0;
  localparam int unsigned MASK  = (1 << PC_W) - 1;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  call_stack_ctrl_if #(.PC_W(PC_W), .OFS_W(OFS_W)) bus ();

  call_stack_ctrl #(
    .PC_W   (PC_W),
    .OFS_W  (OFS_W),
    .DEPTH  (DEPTH),
    .IRQ_VEC(11'h7F0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the stack is a queue, modes are two flags.
  int unsigned m_pc;
  int unsigned m_stack[$];
  bit          m_bubble;
  bit          m_faulted;
  int unsigned m_code;
  bit          m_ack;
  bit          m_valid = 1'b0;

  function automatic int signed sext(input logic [OFS_W-1:0] o);
    return o[OFS_W-1] ? int'(o) - (1 << OFS_W) : int'(o);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 0; m_stack.delete(); m_bubble = 0; m_faulted = 0; m_code = 0; m_ack = 0;
      m_valid = 1'b1;
    end else if (!bus.enable) begin
      m_ack = 0;
    end else begin
      m_ack = 0;
      if (m_faulted) begin
        if (bus.clr_fault) begin
          m_pc = 0; m_stack.delete(); m_code = 0; m_faulted = 0;
        end
      end else if (m_bubble) begin
        m_bubble = 0;
      end else if (bus.irq_req) begin
        if (m_stack.size() == DEPTH) begin m_code = 3; m_faulted = 1; end
        else begin m_stack.push_back(m_pc); m_pc = IRQ_V; m_ack = 1; m_bubble = 1; end
      end else if (bus.ret_req) begin
        if (m_stack.size() == 0) begin m_code = 2; m_faulted = 1; end
        else begin m_pc = (m_stack.pop_back() + 1) & MASK; m_bubble = 1; end
      end else if (bus.call_req) begin
        if (m_stack.size() == DEPTH) begin m_code = 1; m_faulted = 1; end
        else begin
          m_stack.push_back(m_pc);
          m_pc = int'(unsigned'(int'(m_pc) + sext(bus.offset))) & MASK;
          m_bubble = 1;
        end
      end else begin
        m_pc = (m_pc + 1) & MASK;
      end
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      check("pc", bus.pc, m_pc);
      check("level", bus.level, m_stack.size());
      check("top", bus.top, (m_stack.size() == 0) ? 0 : m_stack[m_stack.size() - 1]);
      check("busy", bus.busy, m_bubble | m_faulted);
      check("irq_ack", bus.irq_ack, m_ack);
      check("fault", bus.fault, m_faulted);
      check("fault_code", bus.fault_code, m_code);
    end
  end

  task automatic step(input bit rn, input bit en, input bit c, input bit r, input bit i,
                      input bit cl, input logic [OFS_W-1:0] ofs);
    @(negedge clk);
    rst_n = rn; bus.enable = en; bus.call_req = c; bus.ret_req = r;
    bus.irq_req = i; bus.clr_fault = cl; bus.offset = ofs;
    @(posedge clk);
    #3;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 1, 0, 0, 0, 0, '0);
  endtask

  task automatic do_reset();
    step(0, 1, 0, 0, 0, 0, '0);
  endtask

  initial begin
    rst_n = 1'b0; bus.enable = 1'b1; bus.call_req = 1'b0; bus.ret_req = 1'b0;
    bus.irq_req = 1'b0; bus.clr_fault = 1'b0; bus.offset = '0;

    // Reset, then idle counting.
    do_reset(); do_reset();
    check("lit_rst_pc", bus.pc, 0);
    check("lit_rst_level", bus.level, 0);
    check("lit_rst_busy", bus.busy, 0);
    for (int k = 1; k <= 3; k++) begin
      idle(1);
      check("lit_idle_pc", bus.pc, k);
    end

    // Call/return round trip from pc 0x005.
    idle(2);
    check("lit_pc5", bus.pc, 'h005);
    step(1, 1, 1, 0, 0, 0, 10'h010);
    check("lit_call_pc", bus.pc, 'h015);
    check("lit_call_top", bus.top, 'h005);
    check("lit_call_busy", bus.busy, 1);
    idle(1);
    check("lit_bubble_busy", bus.busy, 0);
    idle(1);
    check("lit_after_pc", bus.pc, 'h016);
    step(1, 1, 0, 1, 0, 0, '0);
    check("lit_ret_pc", bus.pc, 'h006);
    check("lit_ret_level", bus.level, 0);
    check("lit_ret_top", bus.top, 0);
    idle(1);

    // Negative offsets with wrap.
    do_reset(); idle(2);
    step(1, 1, 1, 0, 0, 0, 10'h3F0);
    check("lit_wrap_neg", bus.pc, 'h7F2);
    do_reset(); idle(4);
    step(1, 1, 1, 0, 0, 0, 10'h3FC);
    check("lit_wrap_zero", bus.pc, 'h000);

    // Call overflow and clear.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 1, 0, 0, 0, 10'h010);
      idle(1);
    end
    step(1, 1, 1, 0, 0, 0, 10'h010);
    check("lit_ovf_fault", bus.fault, 1);
    check("lit_ovf_code", bus.fault_code, 1);
    check("lit_ovf_level", bus.level, 4);
    check("lit_ovf_pc", bus.pc, 'h040);
    step(1, 1, 0, 0, 0, 1, '0);
    check("lit_clr_pc", bus.pc, 0);
    check("lit_clr_level", bus.level, 0);
    check("lit_clr_busy", bus.busy, 0);

    // Return underflow, call ignored in FAULT, reset recovery.
    do_reset();
    step(1, 1, 0, 1, 0, 0, '0);
    check("lit_unf_code", bus.fault_code, 2);
    step(1, 1, 1, 0, 0, 0, 10'h010);
    check("lit_unf_hold_pc", bus.pc, 0);
    check("lit_unf_hold_lvl", bus.level, 0);
    do_reset();
    check("lit_unf_rst_fault", bus.fault, 0);
    check("lit_unf_rst_code", bus.fault_code, 0);

    // Interrupt beats coincident call.
    do_reset(); idle('h30);
    step(1, 1, 1, 0, 1, 0, 10'h010);
    check("lit_irq_pc", bus.pc, 'h7F0);
    check("lit_irq_ack", bus.irq_ack, 1);
    check("lit_irq_top", bus.top, 'h030);
    check("lit_irq_level", bus.level, 1);
    idle(1);
    check("lit_irq_ack_off", bus.irq_ack, 0);
    step(1, 1, 0, 1, 0, 0, '0);
    check("lit_irq_ret_pc", bus.pc, 'h031);

    // Stall right after an interrupt acceptance drops irq_ack.
    do_reset();
    step(1, 1, 0, 0, 1, 0, '0);
    step(1, 0, 0, 0, 0, 0, '0);
    check("lit_stall_ack", bus.irq_ack, 0);
    check("lit_stall_pc", bus.pc, 'h7F0);

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 15),
           OFS_W'($urandom));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
